// File: rtl/ray_aabb_err_monitor.sv
// ray_aabb_err_monitor
// On-chip precision checker for the Ray/AABB result path. The golden hit bit
// issued with each ray is delayed LATENCY cycles so that it lines up with the
// DUT hit_miss output. The two bits are then compared, and Type1 errors
// (golden hit, DUT miss) and Type2 errors (golden miss, DUT hit) are counted.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        pulse, accepted in IDLE/DONE only: clears counters, starts a run
//   in_valid     a ray is issued to the DUT this cycle
//   ref_hit      golden hit bit for the ray issued this cycle
//   dut_hit      DUT hit_miss output
//   busy, done   run in progress (RUN/DRAIN) / run complete (DONE)
//   type1_cnt    ref=1, dut=0 mismatches (saturating)
//   type2_cnt    ref=0, dut=1 mismatches (saturating)
//   ref_hit_cnt  compared rays with ref=1 (saturating)
//   cmp_cnt      rays compared so far, capped at NUM_RAYS
//
// Optional build macro RAABB_ERR_LOG_EN adds first_t1_vld/first_t1_idx and
// first_t2_vld/first_t2_idx. These hold the compare index of the first Type1
// and the first Type2 error of a run.
//
// IDX_W must be wide enough to hold the value NUM_RAYS itself, not just
// NUM_RAYS-1, because cmp_cnt ends a run at NUM_RAYS.
module ray_aabb_err_monitor #(
  parameter int LATENCY  = 34,
  parameter int NUM_RAYS = 10000,
  parameter int CNT_W    = 16,
  parameter int IDX_W    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             ref_hit,
  input  logic             dut_hit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] type1_cnt,
  output logic [CNT_W-1:0] type2_cnt,
  output logic [CNT_W-1:0] ref_hit_cnt,
  output logic [IDX_W-1:0] cmp_cnt
`ifdef RAABB_ERR_LOG_EN
  ,
  output logic             first_t1_vld,
  output logic [IDX_W-1:0] first_t1_idx,
  output logic             first_t2_vld,
  output logic [IDX_W-1:0] first_t2_idx
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAYS - 1);
  localparam logic [IDX_W-1:0] RAYS_IDX = IDX_W'(NUM_RAYS);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t             state_r, state_nx_s;
  logic               busy_r, done_r, busy_nx_s, done_nx_s;
  logic               start_acc_s, accept_s, last_acc_s;
  logic               cmp_en_s, cmp_ref_s, t1_hit_s, t2_hit_s;
  logic [LATENCY-1:0] vld_sr_r, ref_sr_r;
  logic [IDX_W-1:0]   iss_idx_r, cmp_cnt_r;
  logic [CNT_W-1:0]   type1_cnt_r, type2_cnt_r, ref_hit_cnt_r;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Qualify start and ray acceptance, and decode the compare slot at the end
  // of the delay line.
  always_comb begin
    start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    accept_s    = in_valid && (state_r == ST_RUN);
    last_acc_s  = accept_s && (iss_idx_r == LAST_IDX);
    cmp_en_s    = vld_sr_r[LATENCY-1] && (cmp_cnt_r != RAYS_IDX);
    cmp_ref_s   = ref_sr_r[LATENCY-1];
    t1_hit_s    = cmp_en_s && cmp_ref_s && !dut_hit;
    t2_hit_s    = cmp_en_s && !cmp_ref_s && dut_hit;
  end

  // State register. busy/done are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_acc_s) state_nx_s = ST_RUN;   else state_nx_s = ST_IDLE;
      ST_RUN:   if (last_acc_s)  state_nx_s = ST_DRAIN; else state_nx_s = ST_RUN;
      ST_DRAIN: if (cmp_cnt_r == RAYS_IDX) state_nx_s = ST_DONE;
                else state_nx_s = ST_DRAIN;
      ST_DONE:  if (start_acc_s) state_nx_s = ST_RUN;   else state_nx_s = ST_DONE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode of the next state.
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    case (state_nx_s)
      ST_RUN, ST_DRAIN: busy_nx_s = 1'b1;
      ST_DONE:          done_nx_s = 1'b1;
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
  end

  // Delay line: shifts every cycle. Bubbles and non-RUN cycles push zeros.
  always_ff @(posedge clk) begin
    if (rst || start_acc_s) begin
      vld_sr_r <= '0;
      ref_sr_r <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        vld_sr_r[i] <= vld_sr_r[i-1];
        ref_sr_r[i] <= ref_sr_r[i-1];
      end
      vld_sr_r[0] <= accept_s;
      ref_sr_r[0] <= accept_s & ref_hit;
    end
  end

  // Issue index of accepted rays.
  always_ff @(posedge clk) begin
    if (rst || start_acc_s) begin
      iss_idx_r <= '0;
    end else if (accept_s) begin
      iss_idx_r <= iss_idx_r + IDX_W'(1);
    end else begin
      iss_idx_r <= iss_idx_r;
    end
  end

  // Compare and error counters.
  always_ff @(posedge clk) begin
    if (rst || start_acc_s) begin
      cmp_cnt_r     <= '0;
      type1_cnt_r   <= '0;
      type2_cnt_r   <= '0;
      ref_hit_cnt_r <= '0;
    end else if (cmp_en_s) begin
      cmp_cnt_r <= cmp_cnt_r + IDX_W'(1);
      if (cmp_ref_s) ref_hit_cnt_r <= sat_inc(ref_hit_cnt_r);
      if (t1_hit_s)  type1_cnt_r   <= sat_inc(type1_cnt_r);
      if (t2_hit_s)  type2_cnt_r   <= sat_inc(type2_cnt_r);
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign type1_cnt   = type1_cnt_r;
  assign type2_cnt   = type2_cnt_r;
  assign ref_hit_cnt = ref_hit_cnt_r;
  assign cmp_cnt     = cmp_cnt_r;

`ifdef RAABB_ERR_LOG_EN
  logic             first_t1_vld_r, first_t2_vld_r;
  logic [IDX_W-1:0] first_t1_idx_r, first_t2_idx_r;

  // First-error log. The index is the compare count before this compare.
  always_ff @(posedge clk) begin
    if (rst || start_acc_s) begin
      first_t1_vld_r <= 1'b0;
      first_t1_idx_r <= '0;
      first_t2_vld_r <= 1'b0;
      first_t2_idx_r <= '0;
    end else begin
      if (t1_hit_s && !first_t1_vld_r) begin
        first_t1_vld_r <= 1'b1;
        first_t1_idx_r <= cmp_cnt_r;
      end
      if (t2_hit_s && !first_t2_vld_r) begin
        first_t2_vld_r <= 1'b1;
        first_t2_idx_r <= cmp_cnt_r;
      end
    end
  end

  assign first_t1_vld = first_t1_vld_r;
  assign first_t1_idx = first_t1_idx_r;
  assign first_t2_vld = first_t2_vld_r;
  assign first_t2_idx = first_t2_idx_r;
`endif

endmodule

// File: tb/tb_ray_aabb_err_monitor.sv
// Directed bench for ray_aabb_err_monitor. It uses three instances:
//   A: LATENCY=4, NUM_RAYS=8,  CNT_W=16
//   B: LATENCY=4, NUM_RAYS=4,  CNT_W=16 (gapped issue)
//   C: LATENCY=2, NUM_RAYS=10, CNT_W=3  (saturation)
// Each scenario fills per-cycle input tables. play() applies the tables and
// logs the outputs at each negedge. Expected values are hand-computed.
module tb_ray_aabb_err_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a_start, a_iv, a_ref, a_dut, a_busy, a_done;
  logic [15:0] a_t1, a_t2, a_rh;
  logic [3:0]  a_cmp;
  logic b_start, b_iv, b_ref, b_dut, b_busy, b_done;
  logic [15:0] b_t1, b_t2, b_rh;
  logic [2:0]  b_cmp;
  logic c_start, c_iv, c_ref, c_dut, c_busy, c_done;
  logic [2:0]  c_t1, c_t2, c_rh;
  logic [3:0]  c_cmp;
`ifdef RAABB_ERR_LOG_EN
  logic a_f1v, a_f2v, b_f1v, b_f2v, c_f1v, c_f2v;
  logic [3:0] a_f1i, a_f2i, c_f1i, c_f2i;
  logic [2:0] b_f1i, b_f2i;
`endif

  ray_aabb_err_monitor #(.LATENCY(4), .NUM_RAYS(8), .CNT_W(16), .IDX_W(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_iv), .ref_hit(a_ref),
    .dut_hit(a_dut), .busy(a_busy), .done(a_done), .type1_cnt(a_t1),
    .type2_cnt(a_t2), .ref_hit_cnt(a_rh), .cmp_cnt(a_cmp)
`ifdef RAABB_ERR_LOG_EN
    , .first_t1_vld(a_f1v), .first_t1_idx(a_f1i),
    .first_t2_vld(a_f2v), .first_t2_idx(a_f2i)
`endif
  );

  ray_aabb_err_monitor #(.LATENCY(4), .NUM_RAYS(4), .CNT_W(16), .IDX_W(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_iv), .ref_hit(b_ref),
    .dut_hit(b_dut), .busy(b_busy), .done(b_done), .type1_cnt(b_t1),
    .type2_cnt(b_t2), .ref_hit_cnt(b_rh), .cmp_cnt(b_cmp)
`ifdef RAABB_ERR_LOG_EN
    , .first_t1_vld(b_f1v), .first_t1_idx(b_f1i),
    .first_t2_vld(b_f2v), .first_t2_idx(b_f2i)
`endif
  );

  ray_aabb_err_monitor #(.LATENCY(2), .NUM_RAYS(10), .CNT_W(3), .IDX_W(4)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .in_valid(c_iv), .ref_hit(c_ref),
    .dut_hit(c_dut), .busy(c_busy), .done(c_done), .type1_cnt(c_t1),
    .type2_cnt(c_t2), .ref_hit_cnt(c_rh), .cmp_cnt(c_cmp)
`ifdef RAABB_ERR_LOG_EN
    , .first_t1_vld(c_f1v), .first_t1_idx(c_f1i),
    .first_t2_vld(c_f2v), .first_t2_idx(c_f2i)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  bit st[32], iv[32], rf[32], db[32], rs[32];
  int done_l[32], busy_l[32], cmp_l[32], t1_l[32], t2_l[32], rh_l[32];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tables();
    for (int c = 0; c < 32; c++) begin
      st[c] = 1'b0; iv[c] = 1'b0; rf[c] = 1'b0; db[c] = 1'b0; rs[c] = 1'b0;
    end
    st[0] = 1'b1;
  endtask

  // Ray k (the leftmost bit of an n-bit pattern is ray 0) is issued at c0+k*stride.
  task automatic load_rays(input int c0, input int n, input int stride,
                           input logic [15:0] rb, input logic [15:0] dbv);
    for (int k = 0; k < n; k++) begin
      iv[c0 + k*stride] = 1'b1;
      rf[c0 + k*stride] = rb[n-1-k];
      db[c0 + k*stride] = dbv[n-1-k];
    end
  endtask

  task automatic zero_inputs();
    a_start = 1'b0; a_iv = 1'b0; a_ref = 1'b0; a_dut = 1'b0;
    b_start = 1'b0; b_iv = 1'b0; b_ref = 1'b0; b_dut = 1'b0;
    c_start = 1'b0; c_iv = 1'b0; c_ref = 1'b0; c_dut = 1'b0;
    rst = 1'b0;
  endtask

  // Apply the tables to one instance. dut_hit in slot c carries the DUT bit of
  // the ray issued at c-lat. Any other slot carries the bubble value bub.
  task automatic play(input int sel, input int ncyc, input int lat, input bit bub);
    bit dh;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      case (sel)
        0: begin done_l[c] = a_done; busy_l[c] = a_busy; cmp_l[c] = int'(a_cmp);
                  t1_l[c] = int'(a_t1); t2_l[c] = int'(a_t2); rh_l[c] = int'(a_rh); end
        1: begin done_l[c] = b_done; busy_l[c] = b_busy; cmp_l[c] = int'(b_cmp);
                  t1_l[c] = int'(b_t1); t2_l[c] = int'(b_t2); rh_l[c] = int'(b_rh); end
        default: begin done_l[c] = c_done; busy_l[c] = c_busy; cmp_l[c] = int'(c_cmp);
                  t1_l[c] = int'(c_t1); t2_l[c] = int'(c_t2); rh_l[c] = int'(c_rh); end
      endcase
      dh = bub;
      if (c >= lat && iv[c-lat]) dh = db[c-lat];
      rst = rs[c];
      case (sel)
        0: begin a_start = st[c]; a_iv = iv[c]; a_ref = rf[c]; a_dut = dh; end
        1: begin b_start = st[c]; b_iv = iv[c]; b_ref = rf[c]; b_dut = dh; end
        default: begin c_start = st[c]; c_iv = iv[c]; c_ref = rf[c]; c_dut = dh; end
      endcase
    end
    @(negedge clk);
    zero_inputs();
  endtask

  initial begin
    zero_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_a_busy", a_busy, 0);   chk("rst_a_done", a_done, 0);
    chk("rst_a_cmp", a_cmp, 0);     chk("rst_a_t1", a_t1, 0);
    chk("rst_b_busy", b_busy, 0);   chk("rst_c_t2", c_t2, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: matching results, continuous issue
    clear_tables();
    load_rays(1, 8, 1, 16'b10110010, 16'b10110010);
    play(0, 17, 4, 1'b0);
    chk("s1_busy_c0", busy_l[0], 0);  chk("s1_busy_c1", busy_l[1], 1);
    chk("s1_cmp_c12", cmp_l[12], 7);  chk("s1_cmp_c13", cmp_l[13], 8);
    chk("s1_done_c13", done_l[13], 0); chk("s1_done_c14", done_l[14], 1);
    chk("s1_busy_c14", busy_l[14], 0);
    chk("s1_t1", t1_l[16], 0); chk("s1_t2", t2_l[16], 0);
    chk("s1_rh", rh_l[16], 4); chk("s1_cmp", cmp_l[16], 8);

    // 2: one Type1 (ray 0), one Type2 (ray 7)
    clear_tables();
    load_rays(1, 8, 1, 16'b10110010, 16'b00110011);
    play(0, 17, 4, 1'b0);
    chk("s2_cleared_cmp", cmp_l[1], 0);
    chk("s2_t1_c5", t1_l[5], 0);  chk("s2_t1_c6", t1_l[6], 1);
    chk("s2_t2_c12", t2_l[12], 0); chk("s2_t2_c13", t2_l[13], 1);
    chk("s2_t1", t1_l[16], 1); chk("s2_t2", t2_l[16], 1);
    chk("s2_rh", rh_l[16], 4); chk("s2_cmp", cmp_l[16], 8);
`ifdef RAABB_ERR_LOG_EN
    chk("s2_f1v", a_f1v, 1); chk("s2_f1i", a_f1i, 0);
    chk("s2_f2v", a_f2v, 1); chk("s2_f2i", a_f2i, 7);
`endif

    // 3: gapped issue, bubble slots carry dut_hit=1
    clear_tables();
    load_rays(1, 4, 2, 16'b1001, 16'b1001);
    play(1, 16, 4, 1'b1);
    chk("s3_cmp_c7", cmp_l[7], 1);   chk("s3_cmp_c8", cmp_l[8], 2);
    chk("s3_done_c12", done_l[12], 0); chk("s3_done_c13", done_l[13], 1);
    chk("s3_cmp", cmp_l[15], 4); chk("s3_t2", t2_l[15], 0);
    chk("s3_t1", t1_l[15], 0);   chk("s3_rh", rh_l[15], 2);

    // 4: extra in_valid after the last ray, start during DRAIN
    clear_tables();
    load_rays(1, 8, 1, 16'b10110010, 16'b10110010);
    for (int c = 9; c < 19; c++) begin
      iv[c] = 1'b1; rf[c] = 1'b0; db[c] = 1'b1;
    end
    st[10] = 1'b1;
    play(0, 22, 4, 1'b1);
    chk("s4_busy_c11", busy_l[11], 1); chk("s4_cmp_c12", cmp_l[12], 7);
    chk("s4_done_c13", done_l[13], 0); chk("s4_done_c14", done_l[14], 1);
    chk("s4_cmp", cmp_l[21], 8); chk("s4_t2", t2_l[21], 0);
    chk("s4_t1", t1_l[21], 0);   chk("s4_rh", rh_l[21], 4);

    // 5: CNT_W=3 saturation with ten Type2 errors
    clear_tables();
    load_rays(1, 10, 1, 16'h0000, 16'h03FF);
    play(2, 17, 2, 1'b0);
    chk("s5_t2_c10", t2_l[10], 7); chk("s5_cmp_c11", cmp_l[11], 8);
    chk("s5_done_c13", done_l[13], 0); chk("s5_done_c14", done_l[14], 1);
    chk("s5_t2", t2_l[16], 7); chk("s5_cmp", cmp_l[16], 10);
    chk("s5_rh", rh_l[16], 0); chk("s5_t1", t1_l[16], 0);
`ifdef RAABB_ERR_LOG_EN
    chk("s5_f2v", c_f2v, 1); chk("s5_f2i", c_f2i, 0); chk("s5_f1v", c_f1v, 0);
`endif

    // 6: rst mid-run, then a clean rerun of scenario 1
    clear_tables();
    load_rays(1, 8, 1, 16'b10110010, 16'b00110011);
    rs[6] = 1'b1;
    play(0, 10, 4, 1'b0);
    chk("s6_cmp_c6", cmp_l[6], 1);  chk("s6_t1_c6", t1_l[6], 1);
    chk("s6_busy_c7", busy_l[7], 0); chk("s6_done_c7", done_l[7], 0);
    chk("s6_cmp_c7", cmp_l[7], 0);  chk("s6_t1_c7", t1_l[7], 0);
    chk("s6_rh_c7", rh_l[7], 0);    chk("s6_t2_c7", t2_l[7], 0);
    chk("s6_cmp_c9", cmp_l[9], 0);  chk("s6_busy_c9", busy_l[9], 0);
    clear_tables();
    load_rays(1, 8, 1, 16'b10110010, 16'b10110010);
    play(0, 17, 4, 1'b0);
    chk("s6r_done_c13", done_l[13], 0); chk("s6r_done_c14", done_l[14], 1);
    chk("s6r_t1", t1_l[16], 0); chk("s6r_t2", t2_l[16], 0);
    chk("s6r_rh", rh_l[16], 4); chk("s6r_cmp", cmp_l[16], 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ray_aabb_err_monitor.md
Name: ray_aabb_err_monitor

Overview:
Synthesizable on-chip checker at the result end of the Ray_AABB_11_4 datapath. It captures the golden (high-precision) hit bit issued alongside each ray and delay-aligns it to the DUT pipeline latency. It then compares that bit with the DUT hit_miss and counts Type1 errors (golden hit, DUT miss) and Type2 errors (golden miss, DUT hit). Used in FPGA self-test builds to measure precision loss of reduced-width Ray/AABB variants without a simulator.

Parameters:
LATENCY, 34, cycles from ray issue (in_valid) to the matching dut_hit, min 1
NUM_RAYS, 10000, rays per run, min 1
CNT_W, 16, width of error and hit counters, saturating
IDX_W, 14, width of ray index counters, must hold NUM_RAYS

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse; clears counters and begins a run (IDLE/DONE only)
in_valid  in  1  a ray is presented to the DUT this cycle
ref_hit  in  1  golden result for the ray issued this cycle
dut_hit  in  1  DUT hit_miss output
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
type1_cnt  out  CNT_W  ref=1, dut=0 mismatches
type2_cnt  out  CNT_W  ref=0, dut=1 mismatches
ref_hit_cnt  out  CNT_W  compared rays with ref=1
cmp_cnt  out  IDX_W  rays compared so far

Behaviour:
- Reset: state IDLE; busy=0, done=0; all counters 0; delay line cleared (all valid bits 0).
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_valid ignored. start -> clear counters and delay line, go to RUN. The start cycle never accepts a ray.
- RUN: in_valid=1 accepts a ray, pushes {1, ref_hit} into a LATENCY-deep shift register, and increments issue index. When the accepted ray is number NUM_RAYS (index NUM_RAYS-1), go to DRAIN next cycle. Later in_valid is ignored.
- DRAIN: no acceptance. When cmp_cnt reaches NUM_RAYS, go to DONE.
- DONE: done=1, counters hold. start -> clear and RUN (same as from IDLE).
- start during RUN/DRAIN: ignored.
- Alignment: a ray accepted at cycle t is compared against dut_hit sampled at cycle t+LATENCY. Counter updates are visible at t+LATENCY+1. A stage with valid=0 performs no compare.
- Compare: cmp_cnt+1 always. ref=1 -> ref_hit_cnt+1, plus type1_cnt+1 if dut_hit=0. ref=0 and dut_hit=1 -> type2_cnt+1.
- Saturation: CNT_W counters stick at all-ones. cmp_cnt never exceeds NUM_RAYS.
- Back-to-back and gapped in_valid are both legal; gaps propagate as bubbles.
- Delay line keeps shifting in every state. In IDLE/DONE it shifts in zeros.
- rst mid-run: immediate return to reset values; in-flight entries discarded.
- No combinational path from inputs to outputs.

Optional Feature:
RAABB_ERR_LOG_EN. When defined, adds outputs first_t1_vld (1), first_t1_idx (IDX_W), first_t2_vld (1) and first_t2_idx (IDX_W). On the first Type1 (Type2) error of a run, the monitor captures the compare index (cmp_cnt value before increment) and sets the sticky vld. All four clear on rst and start. When undefined, these ports and their logic do not exist and the behaviour above is unchanged.

Test Plan:
1. LATENCY=4, NUM_RAYS=8, ref=10110010, dut (delayed 4) identical, in_valid continuous -> done 1 cycle after cmp_cnt=8; type1=0, type2=0, ref_hit_cnt=4; done asserts 4+8+1 cycles after first accept plus DRAIN transition.
2. Same ref; dut=00110011 aligned -> type1=1 (ray 0), type2=1 (ray 7), ref_hit_cnt=4. With RAABB_ERR_LOG_EN: first_t1_idx=0, first_t2_idx=7.
3. in_valid pattern 1,0,1,0..., NUM_RAYS=4, with dut_hit driven 1 during bubble compare slots -> bubbles not counted; cmp_cnt=4, type2=0 when ref=dut on valid slots.
4. 10 extra in_valid pulses after NUM_RAYS accepted, plus start during DRAIN -> cmp_cnt stays 8, counters unaffected, run completes normally.
5. CNT_W=3, 10 consecutive Type2 errors -> type2_cnt=7 (saturated), cmp_cnt=10.
6. rst at cycle 6 of RUN -> next cycle all outputs 0, state IDLE; then start and rerun of scenario 1 gives identical results (no stale compares).
